// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART TX frame sequencer: state encoding and
// TX output mux select codes.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] MUX_PAR   = 2'b00;
  localparam logic [1:0] MUX_DATA  = 2'b01;
  localparam logic [1:0] MUX_STOP  = 2'b10;
  localparam logic [1:0] MUX_START = 2'b11;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Request/control bundle between the upstream requester, the frame sequencer,
// the TX output mux and the serializer.
//
// Handshake: Data_Valid is a level request. The sequencer accepts it only at
// an edge where a new frame may begin (IDLE, or the last cycle of STOP); at any
// other time it is ignored, not queued. busy is high for every cycle of a
// frame. PAR_EN is sampled together with an accepted Data_Valid.
interface uart_tx_fsm_if;

  logic       Data_Valid;
  logic       PAR_EN;
  logic [1:0] mux_sel;
  logic       ser_load;
  logic       ser_en;
  logic       busy;

  // Requester side (and test driver)
  modport master (
    output Data_Valid,
    output PAR_EN,
    input  mux_sel,
    input  ser_load,
    input  ser_en,
    input  busy
  );

  // Sequencer side
  modport slave (
    input  Data_Valid,
    input  PAR_EN,
    output mux_sel,
    output ser_load,
    output ser_en,
    output busy
  );

endinterface

// File: rtl/uart_tx_fsm.sv
// UART TX frame sequencer. One state per baud-clock cycle: START, DATA_WIDTH
// DATA cycles, optional PARITY, STOP. Outputs are decoded from the state
// register only, so the mux and serializer strobes change right after the edge.
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic         CLK,
  input  logic         RST,
  uart_tx_fsm_if.slave tx_if,
  output state_t       state_dbg_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_en_q, par_en_d;

  assign state_dbg_o = state_q;

  // State, bit counter and latched parity enable; reset may land mid-frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
    end
  end

  // Next-state logic and Moore output decode from the current state.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    par_en_d       = par_en_q;
    tx_if.mux_sel  = MUX_STOP;
    tx_if.ser_load = 1'b0;
    tx_if.ser_en   = 1'b0;
    tx_if.busy     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tx_if.Data_Valid) begin
          state_d  = ST_START;
          par_en_d = tx_if.PAR_EN;
        end
      end

      ST_START: begin
        tx_if.mux_sel  = MUX_START;
        tx_if.busy     = 1'b1;
        tx_if.ser_load = 1'b1;
        state_d        = ST_DATA;
        cnt_d          = '0;
      end

      ST_DATA: begin
        tx_if.mux_sel = MUX_DATA;
        tx_if.busy    = 1'b1;
        tx_if.ser_en  = 1'b1;
        if (cnt_q == LAST_BIT) begin
          // Clear on exit so the counter never wraps inside DATA.
          cnt_d   = '0;
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PARITY: begin
        tx_if.mux_sel = MUX_PAR;
        tx_if.busy    = 1'b1;
        state_d       = ST_STOP;
      end

      ST_STOP: begin
        tx_if.mux_sel = MUX_STOP;
        tx_if.busy    = 1'b1;
        // Back-to-back frames skip IDLE entirely.
        if (tx_if.Data_Valid) begin
          state_d  = ST_START;
          par_en_d = tx_if.PAR_EN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        // Unused encodings fall back to IDLE on the next edge.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Testbench for uart_tx_fsm: directed scenarios followed by random requests,
// checked cycle by cycle against a frame-position model.
module tb_uart_tx_fsm;
  import uart_tx_pkg::*;

  localparam int W = 8;

  logic   CLK;
  logic   RST;
  state_t dbg_state;

  uart_tx_fsm_if tx_if ();

  uart_tx_fsm #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .tx_if      (tx_if),
    .state_dbg_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- counters ----------------
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // A frame is a sequence of positions 0..len-1:
  //   0 -> start bit, 1..W -> data bits, W+1 -> parity (if len==W+3),
  //   len-1 -> stop bit. A new frame may begin when idle or at the stop bit.
  bit m_active = 1'b0;
  int m_pos    = 0;
  int m_len    = 0;

  function automatic void model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_len    = 0;
  endfunction

  function automatic void model_edge(input bit dv, input bit pen);
    if (!m_active || m_pos == m_len - 1) begin
      if (dv) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_len    = W + 2 + (pen ? 1 : 0);
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_pos = m_pos + 1;
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [1:0] e_mux;
    logic       e_busy, e_load, e_en;
    e_mux  = 2'b10;
    e_busy = 1'b0;
    e_load = 1'b0;
    e_en   = 1'b0;
    if (m_active) begin
      e_busy = 1'b1;
      if (m_pos == 0) begin
        e_mux  = 2'b11;
        e_load = 1'b1;
      end else if (m_pos >= 1 && m_pos <= W) begin
        e_mux = 2'b01;
        e_en  = 1'b1;
      end else if (m_pos == W + 1 && m_len == W + 3) begin
        e_mux = 2'b00;
      end else begin
        e_mux = 2'b10;
      end
    end

    checks++;
    assert (tx_if.mux_sel === e_mux) else begin
      errors++;
      $error("FAIL %s mux_sel observed=%b expected=%b", tag, tx_if.mux_sel, e_mux);
    end
    checks++;
    assert (tx_if.busy === e_busy) else begin
      errors++;
      $error("FAIL %s busy observed=%b expected=%b", tag, tx_if.busy, e_busy);
    end
    checks++;
    assert (tx_if.ser_load === e_load) else begin
      errors++;
      $error("FAIL %s ser_load observed=%b expected=%b", tag, tx_if.ser_load, e_load);
    end
    checks++;
    assert (tx_if.ser_en === e_en) else begin
      errors++;
      $error("FAIL %s ser_en observed=%b expected=%b", tag, tx_if.ser_en, e_en);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive inputs, take one edge, advance the model, check 1 time unit later.
  task automatic step(input bit dv, input bit pen, input string tag);
    tx_if.Data_Valid = dv;
    tx_if.PAR_EN     = pen;
    @(posedge CLK);
    if (RST) model_edge(dv, pen);
    #1;
    check_outputs(tag);
  endtask

  // Assert reset between edges and check that outputs drop immediately.
  task automatic async_reset(input string tag);
    #2;
    RST = 1'b0;
    model_reset();
    #1;
    check_outputs(tag);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST              = 1'b0;
    tx_if.Data_Valid = 1'b0;
    tx_if.PAR_EN     = 1'b0;
    model_reset();

    // Reset state
    #3;
    check_outputs("reset");
    step(1'b1, 1'b1, "in_reset_dv_ignored");
    @(negedge CLK);
    RST = 1'b1;

    // Idle with no request
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "idle");

    // Single parity frame
    step(1'b1, 1'b1, "par_accept");
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, "par_frame");

    // Single frame without parity
    step(1'b1, 1'b0, "nopar_accept");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, "nopar_frame");

    // Held request: back-to-back parity frames, STOP straight into START
    for (int i = 0; i < 22; i++) step(1'b1, 1'b1, "b2b_held");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "b2b_drain");

    // PAR_EN dropped mid-frame and a stray request during DATA
    step(1'b1, 1'b1, "midchg_accept");
    step(1'b0, 1'b1, "midchg_start");
    step(1'b0, 1'b0, "midchg_pen_drop");
    step(1'b1, 1'b0, "midchg_dv_pulse");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "midchg_tail");

    // Reset in the 4th DATA cycle
    step(1'b1, 1'b0, "rst_accept");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "rst_pre");
    async_reset("rst_mid_data");
    step(1'b0, 1'b0, "rst_after");
    step(1'b1, 1'b1, "rst_new_accept");
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, "rst_new_frame");

    // Random requests
    for (int i = 0; i < 400; i++) begin
      bit dv, pen;
      dv  = ($urandom_range(0, 3) == 0);
      pen = $urandom_range(0, 1) != 0;
      step(dv, pen, "random");
      if ($urandom_range(0, 99) == 0) async_reset("random_reset");
    end

    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
